// File: rtl/trace_capture.sv
// trace_capture
//   Synthesizable instruction-trace buffer. Every instruction fetch seen while
//   capturing is recorded as {timestamp, PC, IR} into a circular buffer.
//   Capture stops on a mode-selected condition (never, buffer full, or halt
//   opcode). The oldest entry is presented on a valid/ready read port.
//
// Ports
//   Clk          rising-edge clock
//   Reset        asynchronous active-low reset
//   Arm          one-cycle pulse: clear the buffer and start capturing
//   Mode         0 wrap, 1 stop when full, 2/3 wrap until halt then stop
//   Fetch_Strobe processor loaded IR this cycle
//   PC_In        PC of the fetched instruction
//   IR_In        fetched instruction
//   Rd_Ready     consumer accepts Rd_Data this cycle
//   Rd_Valid     Rd_Data holds an unread entry
//   Rd_Data      {timestamp, PC, IR} of the oldest stored entry
//   Count        number of entries currently stored
//   Capturing    buffer is in the capture state
//   Halted       sticky: halt opcode captured since last Arm
//   Overflow     sticky: an entry was overwritten or dropped since last Arm

module trace_capture #(
  parameter int PC_W  = 7,
  parameter int IR_W  = 16,
  parameter int TS_W  = 16,
  parameter int DEPTH = 16,
  parameter logic [IR_W-1:0] HALT_IR = 16'h5000
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        Arm,
  input  logic [1:0]                  Mode,
  input  logic                        Fetch_Strobe,
  input  logic [PC_W-1:0]             PC_In,
  input  logic [IR_W-1:0]             IR_In,
  input  logic                        Rd_Ready,
  output logic                        Rd_Valid,
  output logic [TS_W+PC_W+IR_W-1:0]   Rd_Data,
  output logic [$clog2(DEPTH):0]      Count,
  output logic                        Capturing,
  output logic                        Halted,
  output logic                        Overflow
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = TS_W + PC_W + IR_W;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    STOPPED
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [TS_W-1:0]    ts_q, ts_d;
  logic               halted_q, halted_d;
  logic               overflow_q, overflow_d;
  logic               mem_we;
  logic               pop;
  logic               cap;
  logic               full;
  logic [ENTRY_W-1:0] mem [DEPTH];

  // State, pointer, counter and flag registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ts_q       <= '0;
      halted_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ts_q       <= ts_d;
      halted_q   <= halted_d;
      overflow_q <= overflow_d;
    end
  end

  // Trace storage has no reset; unread slots are masked by Count.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= {ts_q, PC_In, IR_In};
    end
  end

  // Next-state logic. Arm overrides any strobe or pop in the same cycle.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ts_d       = ts_q;
    halted_d   = halted_q;
    overflow_d = overflow_q;
    mem_we     = 1'b0;

    pop  = (count_q != '0) && Rd_Ready;
    cap  = (state_q == CAPTURE) && Fetch_Strobe;
    full = (count_q == FULL_COUNT);

    if (Arm) begin
      state_d    = CAPTURE;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      ts_d       = '0;
      halted_d   = 1'b0;
      overflow_d = 1'b0;
    end else begin
      if ((state_q == CAPTURE) && (ts_q != '1)) begin
        ts_d = ts_q + TS_W'(1);
      end

      if (cap) begin
        // A full buffer in stop-when-full mode can only be reached by a mode
        // change mid-capture; the fetch is dropped rather than overwriting.
        if (full && !pop && (Mode == 2'd1)) begin
          overflow_d = 1'b1;
        end else begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
          end else if (full) begin
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            overflow_d = 1'b1;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end

        if (IR_In == HALT_IR) begin
          halted_d = 1'b1;
          if (Mode[1]) begin
            state_d = STOPPED;
          end
        end

        if ((Mode == 2'd1) && (count_d == FULL_COUNT)) begin
          state_d = STOPPED;
        end
      end else if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d  = count_q - CNT_W'(1);
      end
    end
  end

  assign Rd_Valid  = (count_q != '0);
  assign Rd_Data   = Rd_Valid ? mem[rd_ptr_q] : '0;
  assign Count     = count_q;
  assign Capturing = (state_q == CAPTURE);
  assign Halted    = halted_q;
  assign Overflow  = overflow_q;

endmodule

// File: tb/tb_trace_capture.sv
// tb_trace_capture
//   Directed bench for trace_capture with DEPTH=16. Inputs change 1 time unit
//   after a rising edge; outputs are sampled at the same point, so each check
//   reflects the edge that just happened.

module tb_trace_capture;

  localparam int PC_W  = 7;
  localparam int IR_W  = 16;
  localparam int TS_W  = 16;
  localparam int DEPTH = 16;

  logic                      Clk;
  logic                      Reset;
  logic                      Arm;
  logic [1:0]                Mode;
  logic                      Fetch_Strobe;
  logic [PC_W-1:0]           PC_In;
  logic [IR_W-1:0]           IR_In;
  logic                      Rd_Ready;
  logic                      Rd_Valid;
  logic [TS_W+PC_W+IR_W-1:0] Rd_Data;
  logic [4:0]                Count;
  logic                      Capturing;
  logic                      Halted;
  logic                      Overflow;

  int compared;
  int mismatched;

  typedef struct {
    logic [PC_W-1:0] pc;
    logic [IR_W-1:0] ir;
    logic [4:0]      exp_count;
    logic            exp_halted;
    logic            exp_capturing;
  } halt_vec_t;

  halt_vec_t halt_vecs [6];

  trace_capture #(
    .PC_W   (PC_W),
    .IR_W   (IR_W),
    .TS_W   (TS_W),
    .DEPTH  (DEPTH),
    .HALT_IR(16'h5000)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Arm         (Arm),
    .Mode        (Mode),
    .Fetch_Strobe(Fetch_Strobe),
    .PC_In       (PC_In),
    .IR_In       (IR_In),
    .Rd_Ready    (Rd_Ready),
    .Rd_Valid    (Rd_Valid),
    .Rd_Data     (Rd_Data),
    .Count       (Count),
    .Capturing   (Capturing),
    .Halted      (Halted),
    .Overflow    (Overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [TS_W+PC_W+IR_W-1:0] entry(input int ts, input int pc, input int ir);
    return {TS_W'(ts), PC_W'(pc), IR_W'(ir)};
  endfunction

  // Drive one cycle of inputs and let the next rising edge consume them.
  task automatic applyStimulus(input logic strobe, input int pc, input int ir,
                               input logic ready, input logic arm);
    Fetch_Strobe = strobe;
    PC_In        = PC_W'(pc);
    IR_In        = IR_W'(ir);
    Rd_Ready     = ready;
    Arm          = arm;
    @(posedge Clk);
    #1;
    Fetch_Strobe = 1'b0;
    Rd_Ready     = 1'b0;
    Arm          = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  initial begin
    compared     = 0;
    mismatched   = 0;
    Reset        = 1'b0;
    Arm          = 1'b0;
    Mode         = 2'd0;
    Fetch_Strobe = 1'b0;
    PC_In        = '0;
    IR_In        = '0;
    Rd_Ready     = 1'b0;

    halt_vecs[0] = '{7'd10, 16'h1234, 5'd1, 1'b0, 1'b1};
    halt_vecs[1] = '{7'd11, 16'h2345, 5'd2, 1'b0, 1'b1};
    halt_vecs[2] = '{7'd12, 16'h5000, 5'd3, 1'b1, 1'b0};
    halt_vecs[3] = '{7'd13, 16'h0001, 5'd3, 1'b1, 1'b0};
    halt_vecs[4] = '{7'd14, 16'h5000, 5'd3, 1'b1, 1'b0};
    halt_vecs[5] = '{7'd15, 16'h0002, 5'd3, 1'b1, 1'b0};

    // Reset, then strobes without Arm must not capture anything.
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, i, 16'h0100 + i, 1'b0, 1'b0);
    checkOutput("idle_count", Count, 0);
    checkOutput("idle_valid", Rd_Valid, 0);
    checkOutput("idle_capturing", Capturing, 0);
    checkOutput("idle_halted", Halted, 0);
    checkOutput("idle_overflow", Overflow, 0);
    checkOutput("idle_rd_data", Rd_Data, 0);

    // Mode 1: stop when full after the 16th strobe.
    $display("[TB] stop-when-full sequence");
    Mode = 2'd1;
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
    checkOutput("m1_arm_capturing", Capturing, 1);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, i, 16'h0100 + i, 1'b0, 1'b0);
      checkOutput($sformatf("m1_capturing_%0d", i), Capturing, (i < 15) ? 1 : 0);
    end
    checkOutput("m1_count", Count, 16);
    checkOutput("m1_overflow", Overflow, 0);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("m1_drain_%0d", i), Rd_Data, entry(i, i, 16'h0100 + i));
      applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
    end
    checkOutput("m1_drained_count", Count, 0);
    checkOutput("m1_drained_valid", Rd_Valid, 0);
    checkOutput("m1_still_stopped", Capturing, 0);

    // Mode 0: wrap, the first four entries are overwritten.
    $display("[TB] wrap sequence");
    Mode = 2'd0;
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, i, 16'h0200 + i, 1'b0, 1'b0);
    checkOutput("m0_count", Count, 16);
    checkOutput("m0_overflow", Overflow, 1);
    checkOutput("m0_capturing", Capturing, 1);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("m0_drain_%0d", i), Rd_Data, entry(4 + i, 4 + i, 16'h0200 + 4 + i));
      applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
    end
    checkOutput("m0_drained_count", Count, 0);

    // Full buffer with simultaneous capture and pop: no overflow.
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, i, 16'h0300 + i, 1'b0, 1'b0);
    checkOutput("full_count", Count, 16);
    checkOutput("full_overflow_pre", Overflow, 0);
    applyStimulus(1'b1, 16, 16'h0310, 1'b1, 1'b0);
    checkOutput("full_pop_count", Count, 16);
    checkOutput("full_pop_overflow", Overflow, 0);
    checkOutput("full_pop_rd_data", Rd_Data, entry(1, 1, 16'h0301));

    // Mode 2: halt opcode stops capture after being recorded.
    $display("[TB] halt sequence");
    Mode = 2'd2;
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, halt_vecs[i].pc, halt_vecs[i].ir, 1'b0, 1'b0);
      checkOutput($sformatf("halt_count_%0d", i), Count, halt_vecs[i].exp_count);
      checkOutput($sformatf("halt_halted_%0d", i), Halted, halt_vecs[i].exp_halted);
      checkOutput($sformatf("halt_capturing_%0d", i), Capturing, halt_vecs[i].exp_capturing);
    end

    // Back-pressure: data and count hold while not ready.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
      checkOutput($sformatf("hold_data_%0d", i), Rd_Data, entry(0, 10, 16'h1234));
      checkOutput($sformatf("hold_count_%0d", i), Count, 3);
    end
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
    checkOutput("halt_drain_1", Rd_Data, entry(1, 11, 16'h2345));
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
    checkOutput("halt_last_entry", Rd_Data, entry(2, 12, 16'h5000));
    checkOutput("halt_last_count", Count, 1);

    // Arm with a strobe and a pop in the same cycle: both ignored.
    applyStimulus(1'b1, 20, 16'h0400, 1'b1, 1'b1);
    checkOutput("arm_pop_count", Count, 0);
    checkOutput("arm_pop_halted", Halted, 0);
    checkOutput("arm_pop_capturing", Capturing, 1);

    // Asynchronous reset in the middle of a wrap capture.
    $display("[TB] async reset sequence");
    Mode = 2'd0;
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, i, 16'h0500 + i, 1'b0, 1'b0);
    checkOutput("pre_reset_count", Count, 7);
    #2 Reset = 1'b0;
    #1;
    checkOutput("async_count", Count, 0);
    checkOutput("async_valid", Rd_Valid, 0);
    checkOutput("async_capturing", Capturing, 0);
    checkOutput("async_rd_data", Rd_Data, 0);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, i, 16'h0600 + i, 1'b0, 1'b0);
    checkOutput("post_reset_capturing", Capturing, 0);
    checkOutput("post_reset_count", Count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/trace_capture.md
Name: trace_capture

Overview:
- Parametrised hardware instruction-trace buffer for the programmable processor. It replaces simulation-only monitoring with synthesizable capture.
- On every instruction fetch it records {timestamp, PC, IR} into a circular buffer.
- It stops on a configurable condition: a halt opcode, buffer full, or never.
- A valid/ready read port drains the captured entries oldest-first.

Parameters:
PC_W, 7, program counter width
IR_W, 16, instruction register width
TS_W, 16, timestamp (cycle counter) width
DEPTH, 16, number of trace entries; power of two, >= 2
HALT_IR, 16'h5000, IR value that marks the halt instruction

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
Arm  input  1  one-cycle pulse: clear buffer and start capture
Mode  input  2  0 = wrap (overwrite oldest), 1 = stop when full, 2 = stop at halt (wrap until halt), 3 = reserved (treated as 2)
Fetch_Strobe  input  1  high for one cycle when the processor loads IR
PC_In  input  PC_W  PC of the fetched instruction
IR_In  input  IR_W  fetched instruction
Rd_Ready  input  1  consumer accepts Rd_Data this cycle
Rd_Valid  output  1  Rd_Data holds an unread entry
Rd_Data  output  TS_W+PC_W+IR_W  {timestamp, PC, IR}, oldest entry first
Count  output  $clog2(DEPTH)+1  entries currently stored
Capturing  output  1  state is CAPTURE
Halted  output  1  sticky: halt opcode captured since last Arm
Overflow  output  1  sticky: an entry was overwritten or dropped since last Arm

Behaviour:
- Reset (Reset=0, asynchronous): state IDLE; pointers, Count and timestamp are 0; Rd_Valid, Capturing, Halted and Overflow are 0; Rd_Data is 0. Storage contents are don't-care.
- States:
  - IDLE: no capture.
  - CAPTURE: capture on Fetch_Strobe.
  - STOPPED: no capture; readout only.
- Arm=1 in any state:
  - Next cycle: wr_ptr=rd_ptr=0, Count=0, timestamp=0, Halted=0, Overflow=0, state=CAPTURE.
  - A Fetch_Strobe in the same cycle as Arm is ignored.
  - A pop in the same cycle as Arm is ignored.
- Timestamp: increments every cycle while in CAPTURE and saturates at all ones. The entry written on a strobe carries the pre-increment value.
- Capture (CAPTURE, Fetch_Strobe=1): write {ts, PC_In, IR_In} at wr_ptr; wr_ptr += 1 modulo DEPTH. Visible on Rd_Data/Count one cycle later.
  - Count < DEPTH: Count += 1.
  - Count == DEPTH, Mode 0 or 2: overwrite the oldest entry; rd_ptr advances with wr_ptr; Count stays DEPTH; Overflow=1.
  - Mode 1: when the write makes Count == DEPTH, the next state is STOPPED.
- Halt: strobe with IR_In == HALT_IR in CAPTURE:
  - Always sets Halted=1.
  - In Mode 2/3: the halt entry is captured (overwrite rules as above), then state goes to STOPPED.
  - In Mode 0/1: capture continues per mode.
- Readout: Rd_Valid = (Count != 0), in any state.
  - Pop when Rd_Valid && Rd_Ready: rd_ptr += 1, Count -= 1.
  - Rd_Data is held stable while Rd_Valid && !Rd_Ready.
- Simultaneous capture and pop in CAPTURE:
  - Count < DEPTH: Count unchanged, both pointers advance.
  - Count == DEPTH in Mode 0/2: the pop consumes the oldest entry, the write fills its slot, and Overflow is not set.
- STOPPED: Fetch_Strobe is ignored and the timestamp is frozen. The state holds until Arm; draining to empty does not leave STOPPED.
- Reset mid-capture: all state is cleared immediately. Previously captured data is unreadable (Count=0).
- Pointers are $clog2(DEPTH) bits and wrap naturally. Count saturates at DEPTH.

Test Plan:
- Reset low then high, no Arm, 5 strobes -> Count=0, Rd_Valid=0, Capturing=0, all flags 0.
- Mode=1, DEPTH=16, Arm, 20 strobes PC=0..19 -> STOPPED after the 16th; Count=16. Drain with Rd_Ready=1 -> PCs 0..15 in order, timestamps strictly increasing; Overflow=0.
- Mode=0, Arm, 20 strobes PC=0..19 -> Count=16, Overflow=1, Capturing=1. Drain -> PCs 4..19.
- Mode=2, Arm, strobes with IR=1234,2345,5000 then 3 more -> Halted=1 and STOPPED after the 5000 entry. Count=3; last Rd_Data IR=5000; later strobes not captured.
- Rd_Ready held 0 for 4 cycles with Rd_Valid=1 -> Rd_Data and Count unchanged; Arm with strobe and Rd_Ready=1 in the same cycle -> Count=0 next cycle.
- Reset=0 pulsed asynchronously (mid-cycle) during Mode 0 capture with Count=7 -> outputs clear without a clock edge; after release, state is IDLE and Count=0.
